// File: rtl/demod_mac_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : demod_mac_scheduler_if
// Brief   : Delay-line, tap/coefficient and result bus of the demod MAC scheduler.
// Revision: 1.0
// ============================================================================
interface demod_mac_scheduler_if #(
  parameter int P_DW    = 5,
  parameter int P_ACC_W = 14
);
  logic                      sample_valid;
  logic                      shift_en;
  logic [2:0]                index;
  logic [3:0]                tap_sel;
  logic signed [P_DW-1:0]    tap_data;
  logic signed [P_DW-1:0]    coef_in;
  logic signed [P_ACC_W-1:0] result_data;
  logic                      result_valid;
  logic                      result_ready;
  logic                      busy;
  logic                      overrun;
  logic [7:0]                overrun_cnt;

  modport master (
    input  sample_valid, tap_data, coef_in, result_ready,
    output shift_en, index, tap_sel, result_data, result_valid, busy, overrun, overrun_cnt
  );

  modport slave (
    output sample_valid, tap_data, coef_in, result_ready,
    input  shift_en, index, tap_sel, result_data, result_valid, busy, overrun, overrun_cnt
  );
endinterface
`default_nettype wire

// File: rtl/demod_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : demod_mac_scheduler
// Brief   : Delay-line shift/phase sequencer and per-shift tap x coef MAC.
// Revision: 1.0
// ============================================================================
module demod_mac_scheduler #(
  parameter int P_TAPS  = 10,
  parameter int P_OSR   = 8,
  parameter int P_DW    = 5,
  parameter int P_ACC_W = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  demod_mac_scheduler_if.master mac_if
);

  localparam int         C_PROD_W     = 2 * P_DW;
  localparam logic [2:0] C_PHASE_LAST = 3'(P_OSR - 1);
  localparam logic [3:0] C_TAP_LAST   = 4'(P_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                    state_q;
  logic [2:0]                phase_q;
  logic [3:0]                tap_sel_q;
  logic signed [P_ACC_W-1:0] acc_q;
  logic signed [P_ACC_W-1:0] result_q;
  logic                      valid_q;
  logic [7:0]                ovr_cnt_q;

  logic                      shift_evt;
  logic                      blocked;
  logic                      drop;
  logic signed [C_PROD_W-1:0] prod;
  logic signed [P_ACC_W-1:0]  acc_sum;

  assign shift_evt = mac_if.sample_valid && (phase_q == 3'd0);
  assign blocked   = (state_q == S_WAIT) || (state_q == S_RUN) ||
                     ((state_q == S_HOLD) && !mac_if.result_ready);
  assign drop      = shift_evt && blocked;

  assign prod    = C_PROD_W'(mac_if.tap_data) * C_PROD_W'(mac_if.coef_in);
  assign acc_sum = acc_q + {{(P_ACC_W - C_PROD_W){prod[C_PROD_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= 3'd0;
      tap_sel_q <= 4'd0;
      acc_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      ovr_cnt_q <= 8'd0;
    end else begin
      // Phase keeps advancing even when the decimated shift is dropped.
      if (mac_if.sample_valid) begin
        phase_q <= (phase_q == C_PHASE_LAST) ? 3'd0 : phase_q + 3'd1;
      end
      if (drop && (ovr_cnt_q != 8'hFF)) begin
        ovr_cnt_q <= ovr_cnt_q + 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (shift_evt) state_q <= S_WAIT;
        end
        S_WAIT: begin
          acc_q     <= '0;
          tap_sel_q <= 4'd0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          acc_q <= acc_sum;
          if (tap_sel_q == C_TAP_LAST) begin
            result_q  <= acc_sum;
            valid_q   <= 1'b1;
            tap_sel_q <= 4'd0;
            state_q   <= S_HOLD;
          end else begin
            tap_sel_q <= tap_sel_q + 4'd1;
          end
        end
        S_HOLD: begin
          // A shift accepted in the same cycle as the handshake restarts directly.
          if (mac_if.result_ready) begin
            valid_q <= 1'b0;
            state_q <= shift_evt ? S_WAIT : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mac_if.shift_en     = mac_if.sample_valid && !drop;
  assign mac_if.index        = phase_q;
  assign mac_if.tap_sel      = tap_sel_q;
  assign mac_if.result_data  = result_q;
  assign mac_if.result_valid = valid_q;
  assign mac_if.busy         = (state_q != S_IDLE);
  assign mac_if.overrun      = drop;
  assign mac_if.overrun_cnt  = ovr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demod_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_demod_mac_scheduler
// Brief   : Scoreboard bench for the demod MAC scheduler.
// Revision: 1.0
// ============================================================================
module tb_demod_mac_scheduler;
  localparam int P_TAPS  = 10;
  localparam int P_OSR   = 8;
  localparam int P_DW    = 5;
  localparam int P_ACC_W = 14;

  logic clk = 1'b0;
  logic reset;

  demod_mac_scheduler_if #(.P_DW(P_DW), .P_ACC_W(P_ACC_W)) mac_if ();

  demod_mac_scheduler #(
    .P_TAPS (P_TAPS),
    .P_OSR  (P_OSR),
    .P_DW   (P_DW),
    .P_ACC_W(P_ACC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mac_if(mac_if)
  );

  always #5 clk = ~clk;

  int tap_tbl [16];
  int coef_tbl[16];
  int sb_q[$];
  int total = 0;
  int bad   = 0;
  int phase_m;
  int ovr_m;

  // Delay line / coefficient ROM model: combinational lookup on tap_sel.
  assign mac_if.tap_data = P_DW'(tap_tbl[mac_if.tap_sel]);
  assign mac_if.coef_in  = P_DW'(coef_tbl[mac_if.tap_sel]);

  task automatic check_eq(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int expected_sum();
    int s = 0;
    for (int k = 0; k < P_TAPS; k++) s += tap_tbl[k] * coef_tbl[k];
    return s;
  endfunction

  always @(negedge clk) begin
    if (!reset && mac_if.result_valid && mac_if.result_ready) begin
      if (sb_q.size() == 0) check_eq("sb_underflow", sb_q.size(), 1);
      else check_eq("result", int'(mac_if.result_data), sb_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one sample in the current cycle and advances to the next cycle.
  task automatic sample(input int exp_shift);
    mac_if.sample_valid = 1'b1;
    #1;
    check_eq("index", int'(mac_if.index), phase_m);
    check_eq("shift_en", int'(mac_if.shift_en), exp_shift);
    check_eq("overrun", int'(mac_if.overrun), int'(phase_m == 0 && exp_shift == 0));
    if (phase_m == 0 && exp_shift == 0 && ovr_m < 255) ovr_m++;
    phase_m = (phase_m + 1) % P_OSR;
    cyc();
  endtask

  task automatic to_phase0();
    while (phase_m != 0) sample(1);
    mac_if.sample_valid = 1'b0;
  endtask

  // Called in the cycle after the accepted shift; lat counts from that edge.
  task automatic wait_valid(output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (!mac_if.result_valid && lat < 60) begin
      if (mac_if.busy) busy_n++;
      cyc();
      lat++;
    end
  endtask

  task automatic set_tables(input int mode);
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0: begin tap_tbl[k] = k + 1; coef_tbl[k] = 1;   end
        1: begin tap_tbl[k] = -16;   coef_tbl[k] = -16; end
        2: begin tap_tbl[k] = 15;    coef_tbl[k] = -16; end
        default: begin
          tap_tbl[k]  = int'($urandom_range(31)) - 16;
          coef_tbl[k] = int'($urandom_range(31)) - 16;
        end
      endcase
    end
  endtask

  task automatic run_one(input int exp, input string tag);
    int lat, bn;
    to_phase0();
    sb_q.push_back(exp);
    sample(1);
    mac_if.sample_valid = 1'b0;
    wait_valid(lat, bn);
    check_eq({tag, "_latency"}, lat, 12);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, bn, n, e;
    reset                = 1'b1;
    mac_if.sample_valid  = 1'b0;
    mac_if.result_ready  = 1'b0;
    phase_m              = 0;
    ovr_m                = 0;
    set_tables(0);
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    check_eq("rst_busy",    int'(mac_if.busy), 0);
    check_eq("rst_valid",   int'(mac_if.result_valid), 0);
    check_eq("rst_data",    int'(mac_if.result_data), 0);
    check_eq("rst_index",   int'(mac_if.index), 0);
    check_eq("rst_tap_sel", int'(mac_if.tap_sel), 0);
    check_eq("rst_ovr_cnt", int'(mac_if.overrun_cnt), 0);
    check_eq("rst_shift",   int'(mac_if.shift_en), 0);

    // Ramp taps, unit coefficients.
    mac_if.result_ready = 1'b1;
    sb_q.push_back(55);
    sample(1);
    mac_if.sample_valid = 1'b0;
    wait_valid(lat, bn);
    check_eq("t1_latency", lat, 12);
    check_eq("t1_busy_cycles", bn, 11);
    cyc();
    check_eq("t1_valid_clr", int'(mac_if.result_valid), 0);
    check_eq("t1_idle", int'(mac_if.busy), 0);

    // Extreme negative values and sign check.
    set_tables(1);
    run_one(2560, "t2a");
    set_tables(2);
    run_one(-2400, "t2b");

    // Backpressure: result held stable.
    set_tables(3);
    e = expected_sum();
    mac_if.result_ready = 1'b0;
    to_phase0();
    sb_q.push_back(e);
    sample(1);
    mac_if.sample_valid = 1'b0;
    wait_valid(lat, bn);
    check_eq("t3_latency", lat, 12);
    repeat (20) begin
      check_eq("t3_hold_valid", int'(mac_if.result_valid), 1);
      check_eq("t3_hold_data", int'(mac_if.result_data), e);
      cyc();
    end
    mac_if.result_ready = 1'b1;
    cyc();
    mac_if.result_ready = 1'b0;
    #1;
    check_eq("t3_valid_clr", int'(mac_if.result_valid), 0);
    check_eq("t3_idle", int'(mac_if.busy), 0);

    // Continuous samples: drop at r=8 (RUN), accept at r=16 (IDLE).
    set_tables(3);
    e = expected_sum();
    mac_if.result_ready = 1'b1;
    to_phase0();
    for (int r = 0; r < 24; r++) begin
      if (r == 0 || r == 16) sb_q.push_back(e);
      sample((r == 8) ? 0 : 1);
    end
    mac_if.sample_valid = 1'b0;
    check_eq("t4_ovr_cnt", int'(mac_if.overrun_cnt), 1);
    wait_valid(lat, bn);
    check_eq("t4_second_valid", int'(mac_if.result_valid), 1);
    cyc();
    check_eq("t4_sb_empty", sb_q.size(), 0);

    // Shift event on the HOLD handshake cycle restarts without overrun.
    set_tables(3);
    e = expected_sum();
    mac_if.result_ready = 1'b0;
    to_phase0();
    sb_q.push_back(e);
    sample(1);
    mac_if.sample_valid = 1'b0;
    wait_valid(lat, bn);
    check_eq("t5_latency1", lat, 12);
    to_phase0();
    mac_if.result_ready = 1'b1;
    sb_q.push_back(e);
    sample(1);
    mac_if.sample_valid = 1'b0;
    check_eq("t5_direct_wait_busy", int'(mac_if.busy), 1);
    check_eq("t5_direct_wait_valid", int'(mac_if.result_valid), 0);
    wait_valid(lat, bn);
    check_eq("t5_latency2", lat, 12);
    cyc();
    check_eq("t5_ovr_cnt", int'(mac_if.overrun_cnt), 1);

    // Reset in the middle of RUN.
    set_tables(3);
    to_phase0();
    sb_q.push_back(expected_sum());
    sample(1);
    mac_if.sample_valid = 1'b0;
    n = 0;
    while (mac_if.tap_sel != 4'd4 && n < 40) begin
      cyc();
      n++;
    end
    check_eq("t6_tap_sel4", int'(mac_if.tap_sel), 4);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb_q.delete();
    phase_m = 0;
    ovr_m   = 0;
    #1;
    check_eq("t6_busy",    int'(mac_if.busy), 0);
    check_eq("t6_valid",   int'(mac_if.result_valid), 0);
    check_eq("t6_data",    int'(mac_if.result_data), 0);
    check_eq("t6_tap_sel", int'(mac_if.tap_sel), 0);
    check_eq("t6_index",   int'(mac_if.index), 0);
    check_eq("t6_ovr_cnt", int'(mac_if.overrun_cnt), 0);
    check_eq("t6_shift",   int'(mac_if.shift_en), 0);
    repeat (15) cyc();
    check_eq("t6_no_result", int'(mac_if.result_valid), 0);

    // Saturating overrun count under sustained backpressure.
    set_tables(3);
    e = expected_sum();
    mac_if.result_ready = 1'b0;
    sb_q.push_back(e);
    sample(1);
    for (int i = 0; i < 300 * P_OSR; i++) sample((phase_m == 0) ? 0 : 1);
    mac_if.sample_valid = 1'b0;
    #1;
    check_eq("t6_ovr_sat", int'(mac_if.overrun_cnt), 255);
    check_eq("t6_ovr_model", int'(mac_if.overrun_cnt), ovr_m);
    check_eq("t6_held_valid", int'(mac_if.result_valid), 1);
    mac_if.result_ready = 1'b1;
    cyc();
    mac_if.result_ready = 1'b0;
    cyc();
    check_eq("t6_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
